mmd_ratio_ctrl: RTL



---
 rtl/mmd_ratio_ctrl_if.sv | 39 +++
 rtl/mmd_ratio_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mmd_ratio_ctrl_if.sv
// Bundle of the ratio-control handshake, divider outputs and (with MMD_STATS_EN) statistics.
// master: the PLL side driving enable/ratio inputs; slave: the mmd_ratio_ctrl block.
interface mmd_ratio_ctrl_if #(
    parameter int unsigned W = 8
) ();
    logic         enable;
    logic [W-1:0] n_int;
    logic [4:0]   dsm_out;
    logic         dsm_req;
    logic         div_pulse;
    logic         div_clk;
    logic [W-1:0] ratio_out;
    logic         ratio_valid;
    logic         sat_flag;
`ifdef MMD_STATS_EN
    logic [15:0]  period_cnt;
    logic [23:0]  ratio_acc;

    modport master (
        output enable, n_int, dsm_out,
        input  dsm_req, div_pulse, div_clk, ratio_out, ratio_valid, sat_flag,
        input  period_cnt, ratio_acc
    );
    modport slave (
        input  enable, n_int, dsm_out,
        output dsm_req, div_pulse, div_clk, ratio_out, ratio_valid, sat_flag,
        output period_cnt, ratio_acc
    );
`else
    modport master (
        output enable, n_int, dsm_out,
        input  dsm_req, div_pulse, div_clk, ratio_out, ratio_valid, sat_flag
    );
    modport slave (
        input  enable, n_int, dsm_out,
        output dsm_req, div_pulse, div_clk, ratio_out, ratio_valid, sat_flag
    );
`endif
endinterface

// File: rtl/mmd_ratio_ctrl.sv
// Multi-modulus divider control: clamps n_int + MASH sample to a legal ratio and runs the
// period down-counter. Define MMD_STATS_EN to add the period_cnt / ratio_acc outputs.
module mmd_ratio_ctrl #(
    parameter int unsigned W         = 8,
    parameter int unsigned MIN_RATIO = 4
) (
    input logic             clk,
    input logic             rst,
    mmd_ratio_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StCount} state_e;

    localparam logic signed [W+1:0] MinSum = (W+2)'(MIN_RATIO);
    localparam logic signed [W+1:0] MaxSum = (W+2)'((1 << W) - 1);

    state_e       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] ratio_q;
    logic         div_pulse_q;
    logic         div_clk_q;
    logic         ratio_valid_q;
    logic         dsm_req_q;
    logic         sat_q;

    logic signed [W+1:0] sum;
    logic [W-1:0]        ratio_calc;
    logic [W-1:0]        thr_new;
    logic [W-1:0]        thr_cur;
    logic [W-1:0]        cnt_dec;
    logic                sat_calc;
    logic                at_end;
    logic                load_now;

    always_comb begin
        sum        = $signed({2'b00, bus.n_int}) + $signed({{(W-3){bus.dsm_out[4]}}, bus.dsm_out});
        ratio_calc = sum[W-1:0];
        sat_calc   = 1'b0;
        if (sum < MinSum) begin
            ratio_calc = W'(MIN_RATIO);
            sat_calc   = 1'b1;
        end else if (sum > MaxSum) begin
            ratio_calc = '1;
            sat_calc   = 1'b1;
        end
        // div_clk is high while cnt exceeds this threshold: first floor(ratio/2) cycles
        thr_new  = ratio_calc - W'(1) - (ratio_calc >> 1);
        thr_cur  = ratio_q - W'(1) - (ratio_q >> 1);
        cnt_dec  = cnt_q - W'(1);
        at_end   = (state_q == StCount) && (cnt_q == '0);
        load_now = (state_q == StLoad) || (at_end && bus.enable);
    end

`ifdef MMD_STATS_EN
    logic [15:0] period_cnt_q;
    logic [23:0] ratio_acc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ratio_q       <= '0;
            div_pulse_q   <= 1'b0;
            div_clk_q     <= 1'b0;
            ratio_valid_q <= 1'b0;
            dsm_req_q     <= 1'b0;
            sat_q         <= 1'b0;
`ifdef MMD_STATS_EN
            period_cnt_q  <= '0;
            ratio_acc_q   <= '0;
`endif
        end else begin
            div_pulse_q   <= at_end;
            ratio_valid_q <= 1'b0;
            dsm_req_q     <= 1'b0;
            if (load_now) begin
                state_q       <= StCount;
                cnt_q         <= ratio_calc - W'(1);
                ratio_q       <= ratio_calc;
                ratio_valid_q <= 1'b1;
                dsm_req_q     <= 1'b1;
                sat_q         <= sat_q | sat_calc;
                div_clk_q     <= (ratio_calc - W'(1)) > thr_new;
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q     <= '0;
                        ratio_q   <= '0;
                        div_clk_q <= 1'b0;
                        if (bus.enable) state_q <= StLoad;
                    end
                    StCount: begin
                        if (at_end) begin
                            // graceful stop: period finished with enable low
                            state_q   <= StIdle;
                            ratio_q   <= '0;
                            div_clk_q <= 1'b0;
                        end else begin
                            cnt_q     <= cnt_dec;
                            div_clk_q <= cnt_dec > thr_cur;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
`ifdef MMD_STATS_EN
            if (at_end) period_cnt_q <= period_cnt_q + 16'd1;
            if (load_now) ratio_acc_q <= ratio_acc_q + 24'(ratio_calc);
`endif
        end
    end

    assign bus.dsm_req     = dsm_req_q;
    assign bus.div_pulse   = div_pulse_q;
    assign bus.div_clk     = div_clk_q;
    assign bus.ratio_out   = ratio_q;
    assign bus.ratio_valid = ratio_valid_q;
    assign bus.sat_flag    = sat_q;
`ifdef MMD_STATS_EN
    assign bus.period_cnt  = period_cnt_q;
    assign bus.ratio_acc   = ratio_acc_q;
`endif
endmodule
